// File: rtl/y_expr_sweep_ctrl_if.sv
// Handshake, datapath drive and result bundle between the sweep controller
// and its board-side driver (start/abort control, Y datapath, reference table).
interface y_expr_sweep_ctrl_if;
   localparam int unsigned TT_W = 16;
   localparam int unsigned MC_W = 5;

   logic            start;
   logic            abort;
   logic            a;
   logic            b;
   logic            c;
   logic            d;
   logic            y;
   logic            busy;
   logic            done;
   logic [TT_W-1:0] truth_table;
   logic [TT_W-1:0] expected;
   logic            pass;
   logic [MC_W-1:0] mismatch_cnt;

   // Board side: issues requests, closes the loop through the datapath.
   modport master (
      output start, abort, y, expected,
      input  a, b, c, d, busy, done, truth_table, pass, mismatch_cnt
   );

   // Controller side.
   modport slave (
      input  start, abort, y, expected,
      output a, b, c, d, busy, done, truth_table, pass, mismatch_cnt
   );
endinterface

// File: rtl/y_expr_sweep_ctrl.sv
// Sweeps {a,b,c,d} through 0..15, holds each vector HOLD_CYCLES+1 clocks and
// samples y into a truth table. Define SWEEP_COMPARE_EN to enable the compare.
module y_expr_sweep_ctrl #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   y_expr_sweep_ctrl_if.slave  sw
);
   localparam int unsigned VEC_W = 4;
   localparam int unsigned TT_W  = 16;
   localparam int unsigned MC_W  = 5;
   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [VEC_W-1:0] VEC_LAST  = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t           state;
   logic [VEC_W-1:0] vec;
   logic [CNT_W-1:0] hold_cnt;
   logic [VEC_W-1:0] abcd;
   logic             busy;
   logic             done;
   logic [TT_W-1:0]  truth_table;
   logic             pass;
   logic [MC_W-1:0]  mismatch_cnt;

   // Sweep sequencer; every output is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         vec          <= '0;
         hold_cnt     <= '0;
         abcd         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         truth_table  <= '0;
         pass         <= 1'b0;
         mismatch_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sw.start && !sw.abort) begin
                  state        <= ST_DRIVE;
                  vec          <= '0;
                  hold_cnt     <= '0;
                  abcd         <= '0;
                  busy         <= 1'b1;
                  truth_table  <= '0;
                  pass         <= 1'b0;
                  mismatch_cnt <= '0;
               end
            end
            ST_DRIVE: begin
               if (sw.abort) begin
                  state <= ST_IDLE;
                  abcd  <= '0;
                  busy  <= 1'b0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state <= ST_SAMPLE;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            ST_SAMPLE: begin
               // An abort here drops the write for the vector on the pins.
               if (sw.abort) begin
                  state <= ST_IDLE;
                  abcd  <= '0;
                  busy  <= 1'b0;
               end else begin
                  truth_table[vec] <= sw.y;
                  if (vec == VEC_LAST) begin
                     state <= ST_DONE;
                     abcd  <= VEC_LAST;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state    <= ST_DRIVE;
                     vec      <= vec + VEC_W'(1);
                     abcd     <= vec + VEC_W'(1);
                     hold_cnt <= '0;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               abcd  <= '0;
`ifdef SWEEP_COMPARE_EN
               pass         <= (truth_table == sw.expected);
               mismatch_cnt <= MC_W'($countones(truth_table ^ sw.expected));
`endif
            end
            default: begin
               state <= ST_IDLE;
               abcd  <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifndef SWEEP_COMPARE_EN
   // Reference table is not consumed without the compare feature.
   logic unused_expected;
   assign unused_expected = ^sw.expected;
`endif

   assign {sw.a, sw.b, sw.c, sw.d} = abcd;
   assign sw.busy         = busy;
   assign sw.done         = done;
   assign sw.truth_table  = truth_table;
   assign sw.pass         = pass;
   assign sw.mismatch_cnt = mismatch_cnt;
endmodule
